// File: rtl/fifo_pkt_arb_pkg.sv
// Shared types and helpers for the packet-aware FIFO push arbiter.
package fifo_pkt_arb_pkg;

  typedef enum logic {ARB, LOCK} arb_state_e;

  // Increment with an explicit wrap, so non-power-of-two requester counts work.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_pkt_arb_rr_pick.sv
// Rotating first-one finder: lowest set valid bit at or after start, wrapping.
module fifo_pkt_arb_rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] start,
  output logic [IDW-1:0] sel,
  output logic           any_valid
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  always_comb begin
    dbl       = {valid, valid};
    masked    = '0;
    sel       = '0;
    any_valid = |valid;
    // The upper copy supplies the wrapped-around candidates below start.
    for (int i = 0; i < 2 * int'(N); i++) begin
      masked[i] = dbl[i] && (i >= int'(start));
    end
    for (int i = 2 * int'(N) - 1; i >= 0; i--) begin
      if (masked[i]) begin
        sel = (i >= int'(N)) ? IDW'(i - int'(N)) : IDW'(i);
      end
    end
  end

endmodule

// File: rtl/fifo_pkt_push_arb.sv
// Packet-aware round-robin arbiter sharing one FIFO push port between N_REQ producers.
module fifo_pkt_push_arb
  import fifo_pkt_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic [N_REQ-1:0]                    req_valid_i,
  input  logic [N_REQ-1:0]                    req_last_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]    req_data_i,
  output logic [N_REQ-1:0]                    req_ready_o,
  input  logic                                fifo_full_i,
  output logic                                fifo_push_o,
  output logic [DATA_WIDTH+IDW:0]             fifo_data_o,
  output logic                                fifo_flush_o,
  output logic                                lock_o,
  output logic [IDW-1:0]                      lock_id_o
);

  arb_state_e     fsm;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] lock_id;

  logic [IDW-1:0] pick_sel;
  logic           pick_any;
  logic [IDW-1:0] sel;
  logic           sel_valid;
  logic           sel_last;
  logic           acc;

  fifo_pkt_arb_rr_pick #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_rr_pick (
    .valid     (req_valid_i),
    .start     (rr_ptr),
    .sel       (pick_sel),
    .any_valid (pick_any)
  );

  always_comb begin
    if (fsm == LOCK) begin
      // The owner keeps the port even while idle; nobody else may interleave.
      sel       = lock_id;
      sel_valid = req_valid_i[lock_id];
    end else begin
      sel       = pick_sel;
      sel_valid = pick_any;
    end
    sel_last = req_last_i[sel];
    acc      = sel_valid & ~fifo_full_i & ~flush_i;

    req_ready_o = '0;
    if (acc) begin
      req_ready_o[sel] = 1'b1;
    end
    fifo_push_o  = acc;
    fifo_data_o  = {sel_last, sel, req_data_i[sel]};
    fifo_flush_o = flush_i;
    lock_o       = (fsm == LOCK);
    lock_id_o    = lock_id;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      fsm     <= ARB;
      rr_ptr  <= '0;
      lock_id <= '0;
    end else if (acc) begin
      unique case (fsm)
        ARB: begin
          if (sel_last) begin
            rr_ptr <= IDW'(rr_next(32'(sel), N_REQ));
          end else begin
            fsm     <= LOCK;
            lock_id <= sel;
          end
        end
        LOCK: begin
          if (sel_last) begin
            fsm     <= ARB;
            rr_ptr  <= IDW'(rr_next(32'(lock_id), N_REQ));
            lock_id <= '0;
          end
        end
        default: fsm <= ARB;
      endcase
    end
  end

endmodule
